io_ring_pwr_seq: RTL and testbench

IO_RING_PWR_SEQ -- requirements
Module: io_ring_pwr_seq

---
 rtl/io_ring_pwr_seq.sv | 172 +++++++++++++++++
 tb/tb_io_ring_pwr_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_ring_pwr_seq.sv
// IO-ring pad-supply power sequencer: ramps VDDQ, waits for settle, releases pad
// retention, then grants output enables; reverses the order on power-down or fault.
module io_ring_pwr_seq #(
  parameter int RAMP_TO    = 1024,
  parameter int SETTLE_CYC = 64,
  parameter int REL_CYC    = 16,
  parameter int DISCH_CYC  = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwr_req,
  input  logic       vddq_good,
  input  logic       err_clr,
  output logic       en_vddq,
  output logic       pad_ret,
  output logic       pad_oe_en,
  output logic       pwr_ack,
  output logic       err,
  output logic [2:0] state
);

  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  localparam int RAMP_E   = at_least_one(RAMP_TO);
  localparam int SETTLE_E = at_least_one(SETTLE_CYC);
  localparam int REL_E    = at_least_one(REL_CYC);
  localparam int DISCH_E  = at_least_one(DISCH_CYC);
  localparam int MAX_A    = (RAMP_E > SETTLE_E) ? RAMP_E : SETTLE_E;
  localparam int MAX_B    = (REL_E > DISCH_E) ? REL_E : DISCH_E;
  localparam int MAX_E    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW       = (MAX_E > 1) ? $clog2(MAX_E) : 1;

  // Loading N-1 and leaving when the count is 0 gives a dwell of exactly N cycles.
  localparam logic [CW-1:0] LD_RAMP   = CW'(RAMP_E - 1);
  localparam logic [CW-1:0] LD_SETTLE = CW'(SETTLE_E - 1);
  localparam logic [CW-1:0] LD_REL    = CW'(REL_E - 1);
  localparam logic [CW-1:0] LD_DISCH  = CW'(DISCH_E - 1);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_RAMP    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_ON      = 3'd4,
    ST_DOWN    = 3'd5,
    ST_DISCH   = 3'd6,
    ST_ERR     = 3'd7
  } st_t;

  st_t           st;
  logic [CW-1:0] cnt;
  logic          vg_meta;
  logic          vg_s;

  assign state = st;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vg_meta <= 1'b0;
      vg_s    <= 1'b0;
    end else begin
      vg_meta <= vddq_good;
      vg_s    <= vg_meta;
    end
  end

  // NOTE: the shared counter is reset too, so no stale count survives a reset taken mid-sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_OFF;
      cnt       <= '0;
      en_vddq   <= 1'b0;
      pad_ret   <= 1'b1;
      pad_oe_en <= 1'b0;
      pwr_ack   <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (st)
        ST_OFF: begin
          if (pwr_req) begin
            st      <= ST_RAMP;
            en_vddq <= 1'b1;
            cnt     <= LD_RAMP;
          end
        end
        ST_RAMP: begin
          if (!pwr_req) begin
            st      <= ST_DOWN;
            pad_ret <= 1'b1;
            cnt     <= LD_REL;
          end else if (vg_s) begin
            st  <= ST_SETTLE;
            cnt <= LD_SETTLE;
          end else if (cnt == '0) begin
            st      <= ST_ERR;
            en_vddq <= 1'b0;
            err     <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SETTLE, ST_RELEASE, ST_ON: begin
          // Loss of supply outranks everything: pads go safe and the switch opens at once.
          if (!vg_s) begin
            st        <= ST_ERR;
            cnt       <= '0;
            en_vddq   <= 1'b0;
            pad_ret   <= 1'b1;
            pad_oe_en <= 1'b0;
            pwr_ack   <= 1'b0;
            err       <= 1'b1;
          end else if (!pwr_req) begin
            st        <= ST_DOWN;
            cnt       <= LD_REL;
            pad_oe_en <= 1'b0;
            pwr_ack   <= 1'b0;
            if (st != ST_ON) pad_ret <= 1'b1;
          end else if (st == ST_ON) begin
            cnt <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (st == ST_SETTLE) begin
            st      <= ST_RELEASE;
            pad_ret <= 1'b0;
            cnt     <= LD_REL;
          end else begin
            st        <= ST_ON;
            pad_oe_en <= 1'b1;
            pwr_ack   <= 1'b1;
            cnt       <= '0;
          end
        end
        ST_DOWN: begin
          if (cnt == '0) begin
            st      <= ST_DISCH;
            pad_ret <= 1'b1;
            en_vddq <= 1'b0;
            cnt     <= LD_DISCH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DISCH: begin
          if (cnt == '0) begin
            st <= ST_OFF;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ERR: begin
          if (err_clr) begin
            st  <= ST_DISCH;
            err <= 1'b0;
            cnt <= LD_DISCH;
          end
        end
        default: begin
          st        <= ST_OFF;
          cnt       <= '0;
          en_vddq   <= 1'b0;
          pad_ret   <= 1'b1;
          pad_oe_en <= 1'b0;
          pwr_ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Scoreboard bench for io_ring_pwr_seq: each stimulus queues the state transitions
// it should cause (state, edge number, outputs); a monitor pops and compares them.
module tb_io_ring_pwr_seq;

  localparam logic [2:0] S_OFF = 3'd0, S_RAMP = 3'd1, S_SETTLE = 3'd2, S_RELEASE = 3'd3,
                         S_ON = 3'd4, S_DOWN = 3'd5, S_DISCH = 3'd6, S_ERR = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwr_req = 1'b0;
  logic       vddq_good = 1'b0;
  logic       err_clr = 1'b0;
  logic       en_vddq, pad_ret, pad_oe_en, pwr_ack, err;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [2:0] st;
    int         at;
    logic [4:0] outs;
  } exp_t;

  exp_t q[$];

  io_ring_pwr_seq dut (
    .clk       (clk),
    .rst       (rst),
    .pwr_req   (pwr_req),
    .vddq_good (vddq_good),
    .err_clr   (err_clr),
    .en_vddq   (en_vddq),
    .pad_ret   (pad_ret),
    .pad_oe_en (pad_oe_en),
    .pwr_ack   (pwr_ack),
    .err       (err),
    .state     (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
    end
  endtask

  // Output vector {en_vddq, pad_ret, pad_oe_en, pwr_ack, err} expected on entry to a state.
  function automatic logic [4:0] outs_for(input logic [2:0] s, input bit ret_held);
    case (s)
      S_OFF, S_DISCH:    return 5'b01000;
      S_RAMP, S_SETTLE:  return 5'b11000;
      S_RELEASE:         return 5'b10000;
      S_ON:              return 5'b10110;
      S_DOWN:            return ret_held ? 5'b11000 : 5'b10000;
      default:           return 5'b01001;
    endcase
  endfunction

  task automatic push(input logic [2:0] s, input int at, input bit ret_held = 1'b0);
    exp_t e;
    e.st   = s;
    e.at   = at;
    e.outs = outs_for(s, ret_held);
    q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic at_neg(output int n);
    @(negedge clk);
    n = cyc;
  endtask

  // Monitor: invariants every cycle, scoreboard compare on each state change.
  initial begin
    logic [2:0] prev = S_OFF;
    exp_t e;
    forever begin
      @(negedge clk);
      check("inv_oe_with_ret", int'(pad_oe_en & pad_ret), 0);
      check("inv_open_without_vddq", int'(!pad_ret & !en_vddq), 0);
      check("oe_only_in_on", int'(pad_oe_en), int'(state == S_ON));
      if (state !== prev) begin
        if (q.size() == 0) begin
          check("unexpected_transition", int'(state), int'(prev));
        end else begin
          e = q.pop_front();
          check("state", int'(state), int'(e.st));
          check("edge", cyc, e.at);
          check("outs", int'({en_vddq, pad_ret, pad_oe_en, pwr_ack, err}), int'(e.outs));
        end
        prev = state;
      end
    end
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d, want finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int m;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_outs", int'({en_vddq, pad_ret, pad_oe_en, pwr_ack, err}), int'(5'b01000));
    check("rst_state", int'(state), int'(S_OFF));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Power-up with vddq_good 10 cycles after the request.
    at_neg(n);
    pwr_req = 1'b1;
    push(S_RAMP, n + 1);
    repeat (10) @(negedge clk);
    vddq_good = 1'b1;
    push(S_SETTLE, n + 13);
    push(S_RELEASE, n + 77);
    push(S_ON, n + 93);
    drain(200);

    // Orderly power-down from ON.
    at_neg(n);
    pwr_req = 1'b0;
    push(S_DOWN, n + 1);
    push(S_DISCH, n + 17);
    push(S_OFF, n + 273);
    drain(400);
    vddq_good = 1'b0;

    // Ramp timeout; pwr_req alone must not leave ERR.
    at_neg(n);
    pwr_req = 1'b1;
    push(S_RAMP, n + 1);
    push(S_ERR, n + 1025);
    drain(1200);
    repeat (5) @(negedge clk);
    check("err_sticky", int'(err), 1);
    at_neg(n);
    pwr_req = 1'b0;
    err_clr = 1'b1;
    push(S_DISCH, n + 1);
    push(S_OFF, n + 257);
    @(negedge clk);
    err_clr = 1'b0;
    drain(400);

    // Abort in the 5th SETTLE cycle.
    at_neg(n);
    pwr_req   = 1'b1;
    vddq_good = 1'b1;
    push(S_RAMP, n + 1);
    push(S_SETTLE, n + 3);
    repeat (7) @(negedge clk);
    pwr_req = 1'b0;
    push(S_DOWN, n + 8, 1'b1);
    push(S_DISCH, n + 24);
    push(S_OFF, n + 280);
    drain(400);

    // Power-up with supply already good, then brown-out in ON.
    at_neg(n);
    pwr_req = 1'b1;
    push(S_RAMP, n + 1);
    push(S_SETTLE, n + 2);
    push(S_RELEASE, n + 66);
    push(S_ON, n + 82);
    drain(200);
    at_neg(n);
    vddq_good = 1'b0;
    push(S_ERR, n + 3);
    drain(20);
    at_neg(n);
    pwr_req = 1'b0;
    err_clr = 1'b1;
    push(S_DISCH, n + 1);
    push(S_OFF, n + 257);
    @(negedge clk);
    err_clr = 1'b0;
    drain(400);

    // Reset while ON: immediate safe outputs, RAMP on the first edge after release.
    at_neg(n);
    pwr_req   = 1'b1;
    vddq_good = 1'b1;
    push(S_RAMP, n + 1);
    push(S_SETTLE, n + 3);
    push(S_RELEASE, n + 67);
    push(S_ON, n + 83);
    drain(200);
    at_neg(n);
    push(S_OFF, n + 1);
    #2 rst = 1'b1;
    #1;
    check("rst_on_outs", int'({en_vddq, pad_ret, pad_oe_en, pwr_ack, err}), int'(5'b01000));
    check("rst_on_state", int'(state), int'(S_OFF));
    repeat (2) @(negedge clk);
    m = cyc;
    rst = 1'b0;
    push(S_RAMP, m + 1);
    push(S_SETTLE, m + 3);
    drain(20);
    at_neg(n);
    pwr_req = 1'b0;
    push(S_DOWN, n + 1, 1'b1);
    push(S_DISCH, n + 17);
    push(S_OFF, n + 273);
    drain(400);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
